cpu_memory_arbiter: RTL

- Shares the single CPU-side memory port between two requesters: the instruction cache fill port (read-only) and the CPU load/store data port (read/write).
- Sits between the instruction cache / CPU core and the system memory controller.
- Serialises requests with one transaction outstanding at a time.
- Data port has priority; a starvation counter guarantees forward progress for instruction fetch.

---
 rtl/cpu_memory_arbiter_pkg.sv | 25 ++
 rtl/cpu_memory_arbiter_if.sv | 50 +++++
 rtl/cpu_mem_arb_priority.sv | 41 ++++
 rtl/cpu_memory_arbiter.sv | 103 ++++++++++
 4 files changed

// File: rtl/cpu_memory_arbiter_pkg.sv
// Shared types for the CPU memory arbiter: FSM states,
// port ownership and byte-lane mask constants.
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IC = 2'd1,
    BUSY_D  = 2'd2,
    RESPOND = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IC   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  localparam logic [1:0] MASK_NONE = 2'b00;
  localparam logic [1:0] MASK_LO   = 2'b01;
  localparam logic [1:0] MASK_HI   = 2'b10;
  localparam logic [1:0] MASK_BOTH = 2'b11;

  localparam int STARVE_BITS = 4;

endpackage

// File: rtl/cpu_memory_arbiter_if.sv
// Bus bundle between the arbiter and its requesters and memory.
// master = arbiter view, slave = icache/core/memory view.
interface cpu_memory_arbiter_if #(
  parameter int ADDRESS_BITS = 16,
  parameter int DATA_BITS    = 16
);
  logic                    ic_ready;
  logic [ADDRESS_BITS-1:0] ic_address;
  logic                    ic_valid;
  logic [DATA_BITS-1:0]    ic_data;

  logic                    d_request;
  logic                    d_wr;
  logic [ADDRESS_BITS-1:0] d_address;
  logic [DATA_BITS-1:0]    d_wdata;
  logic [1:0]              d_wmask;
  logic                    d_valid;
  logic [DATA_BITS-1:0]    d_rdata;

  logic                    mem_req;
  logic                    mem_wr;
  logic [ADDRESS_BITS-1:0] mem_address;
  logic [DATA_BITS-1:0]    mem_wdata;
  logic [1:0]              mem_wmask;
  logic                    mem_ack;
  logic [DATA_BITS-1:0]    mem_rdata;

  modport master (
    input  ic_ready, ic_address,
    input  d_request, d_wr, d_address,
    input  d_wdata, d_wmask,
    input  mem_ack, mem_rdata,
    output ic_valid, ic_data,
    output d_valid, d_rdata,
    output mem_req, mem_wr, mem_address,
    output mem_wdata, mem_wmask
  );

  modport slave (
    output ic_ready, ic_address,
    output d_request, d_wr, d_address,
    output d_wdata, d_wmask,
    output mem_ack, mem_rdata,
    input  ic_valid, ic_data,
    input  d_valid, d_rdata,
    input  mem_req, mem_wr, mem_address,
    input  mem_wdata, mem_wmask
  );

endinterface

// File: rtl/cpu_mem_arb_priority.sv
// Grant decision for the arbiter: data first, but the icache is
// forced ahead once it has waited through STARVE_LIMIT data grants.
module cpu_mem_arb_priority
  import cpu_mem_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic CLK,
  input  logic RSTb,
  input  logic idle,
  input  logic ic_ready,
  input  logic d_request,
  output logic grant_ic,
  output logic grant_d
);

  localparam logic [STARVE_BITS-1:0] LIMIT =
    STARVE_BITS'(STARVE_LIMIT);

  logic [STARVE_BITS-1:0] starve_q;
  logic                   ic_starved;

  always_comb begin
    ic_starved = ic_ready && (starve_q == LIMIT);
    grant_d    = idle && d_request && !ic_starved;
    grant_ic   = idle && ic_ready && !grant_d;
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      starve_q <= '0;
    end else if (idle) begin
      if (!ic_ready || grant_ic) begin
        starve_q <= '0;
      end else if (grant_d && starve_q != LIMIT) begin
        starve_q <= starve_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_memory_arbiter.sv
// Shares one memory port between icache fill and CPU data port,
// one transaction outstanding, registered request to memory.
module cpu_memory_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDRESS_BITS = 16,
  parameter int DATA_BITS    = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 CLK,
  input  logic                 RSTb,
  cpu_memory_arbiter_if.master bus
);

  arb_state_e state_q, state_d;
  owner_e     owner_q;
  logic       grant_ic, grant_d;
  logic       busy;

  logic [ADDRESS_BITS-1:0] addr_q;
  logic [DATA_BITS-1:0]    wdata_q;
  logic [1:0]              wmask_q;
  logic                    wr_q;
  logic [DATA_BITS-1:0]    ic_data_q;
  logic [DATA_BITS-1:0]    d_rdata_q;

  cpu_mem_arb_priority #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_prio (
    .CLK      (CLK),
    .RSTb     (RSTb),
    .idle     (state_q == IDLE),
    .ic_ready (bus.ic_ready),
    .d_request(bus.d_request),
    .grant_ic (grant_ic),
    .grant_d  (grant_d)
  );

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (grant_d)       state_d = BUSY_D;
        else if (grant_ic) state_d = BUSY_IC;
      end
      BUSY_IC, BUSY_D: begin
        if (bus.mem_ack) state_d = RESPOND;
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request fields are frozen at grant; later requester changes are ignored.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      wmask_q   <= MASK_NONE;
      wr_q      <= 1'b0;
      owner_q   <= OWN_NONE;
      ic_data_q <= '0;
      d_rdata_q <= '0;
    end else begin
      if (grant_d) begin
        addr_q  <= bus.d_address;
        wdata_q <= bus.d_wdata;
        wmask_q <= bus.d_wmask;
        wr_q    <= bus.d_wr;
        owner_q <= OWN_D;
      end else if (grant_ic) begin
        addr_q  <= bus.ic_address;
        wdata_q <= '0;
        wmask_q <= MASK_NONE;
        wr_q    <= 1'b0;
        owner_q <= OWN_IC;
      end
      if (state_q == BUSY_IC && bus.mem_ack)
        ic_data_q <= bus.mem_rdata;
      if (state_q == BUSY_D && bus.mem_ack)
        d_rdata_q <= bus.mem_rdata;
    end
  end

  assign busy = (state_q == BUSY_IC) || (state_q == BUSY_D);

  assign bus.mem_req     = busy;
  assign bus.mem_wr      = wr_q;
  assign bus.mem_address = addr_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.mem_wmask   = wmask_q;

  assign bus.ic_valid = (state_q == RESPOND) && (owner_q == OWN_IC);
  assign bus.d_valid  = (state_q == RESPOND) && (owner_q == OWN_D);
  assign bus.ic_data  = ic_data_q;
  assign bus.d_rdata  = d_rdata_q;

endmodule
